soc_event_token_tx: RTL and testbench
=====================================

Name: soc_event_token_tx

Overview:
- Parametrised successor of the single-channel cluster event-bus writer (cluster_events_wt/rp/da), sitting in the SoC domain.
- Arbitrates NB_CH event producers (DMA, peripherals, FC) round-robin into a BUFFER_DEPTH-entry token-ring buffer.
- Exports the one-hot write token and the flattened slot array to the cluster-side reader, and takes back the reader's one-hot read pointer.
- Tags every event with its source channel ID and reports buffer occupancy.

Parameters:
NB_CH, 4, number of event producer channels (>=1)
EVNT_WIDTH, 8, payload bits per event
BUFFER_DEPTH, 8, token-ring slots (>=3); usable capacity BUFFER_DEPTH-1
CH_W, max(1,$clog2(NB_CH)), channel ID width (derived, do not override)
SYNC_STAGES, 2, flops on each read-pointer bit (>=2)

Ports:
clk_i  in  1  SoC clock
rst_ni  in  1  asynchronous active-low reset
evt_valid_i  in  NB_CH  per-channel event request
evt_data_i  in  NB_CH*EVNT_WIDTH  per-channel payload; channel c at [c*EVNT_WIDTH +: EVNT_WIDTH]
evt_ack_o  out  NB_CH  one-hot accept strobe, same cycle as acceptance
events_wt_o  out  BUFFER_DEPTH  one-hot write token to reader
events_rp_i  in  BUFFER_DEPTH  one-hot read pointer from reader (asynchronous)
events_da_o  out  BUFFER_DEPTH*(CH_W+EVNT_WIDTH)  slot array; slot s = {ch_id, payload}
full_o  out  1  no free slot this cycle
fill_o  out  $clog2(BUFFER_DEPTH)+1  occupied slots

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low. All flops reset asynchronously on rst_ni low.
- Reset values:
  - events_wt_o = 1 (bit 0).
  - Synchroniser stages reset to 1.
  - events_da_o = 0, rr_ptr = 0, full_o = 0, fill_o = 0.
  - evt_ack_o = 0 while in reset.
- Read-pointer sync: rp_sync = events_rp_i after SYNC_STAGES flops per bit; no other logic on events_rp_i.
- Full:
  - full = ((rp_sync & rotl1(events_wt_o)) != 0) OR (rp_sync == 0).
  - A zero or two-hot rp_sync during a reader transition is therefore treated conservatively as full.
  - full_o = full (combinational from flops).
- Arbitration:
  - Requests are evt_valid_i.
  - Winner = first set bit scanning from rr_ptr upward, modulo NB_CH.
  - evt_ack_o = onehot(winner) when any request is set and !full, else 0.
  - Ack is combinational; the source holds valid and data stable until ack, then may drop or present its next event.
  - At most one acceptance per cycle.
- Write on acceptance (single edge):
  - Slot idx(events_wt_o) <= {winner[CH_W-1:0], evt_data_i[winner]}.
  - events_wt_o <= rotl1(events_wt_o).
  - rr_ptr <= (winner+1) mod NB_CH.
  - Non-accepting cycles hold every register. Slot contents are never cleared by reads.
- Wrap-around: token bit BUFFER_DEPTH-1 rotates to bit 0; the slot index follows.
- Fairness: with all channels continuously requesting and no full stalls, each channel is granted exactly once every NB_CH accepts.
- Occupancy:
  - When rp_sync is one-hot: fill_o registered as (idx(wt_next) - idx(rp_sync)) mod BUFFER_DEPTH.
  - Otherwise fill_o holds its value.
  - Max value BUFFER_DEPTH-1.
- Simultaneous accept and reader advance: both take effect. The rp change is visible only after SYNC_STAGES, so the stall release lags the reader by SYNC_STAGES cycles.
- Reset mid-operation: pending un-acked requests are lost from the buffer's view (sources re-present); token and contents return to reset values. The reader must be reset together.
- NB_CH=1: arbiter degenerates to a pass-through; ch_id field is 1 bit, constant 0.

Test Plan:
- Basic accept:
  - Setup: NB_CH=4, EVNT_WIDTH=8, BUFFER_DEPTH=8, reader rp held at 1; ch2 valid with data 0xA5.
  - Required: evt_ack_o=4'b0100 the same cycle.
  - Next cycle: events_wt_o=8'h02, slot0=10'h2A5 ({2'b10,8'hA5}), fill_o=1.
- Fill to full:
  - Stimulus: rp held at 1; 7 accepts from ch0 with data 0..6.
  - Required: wt=8'h80, full_o=1, fill_o=7.
  - Then an 8th request gets evt_ack_o=0 and slot7 is unchanged.
- Drain and wrap:
  - Stimulus: from the full state, reader sets rp=8'h02.
  - Required: full_o drops exactly SYNC_STAGES=2 cycles later; the next accept writes slot7; wt becomes 8'h01; fill_o=7.
- Round-robin:
  - Stimulus: all 4 channels valid continuously, reader tracks wt minus 1 so the buffer never fills.
  - Required: ack sequence 0001,0010,0100,1000,0001; ch_id fields in successive slots are 0,1,2,3,0.
- Glitchy rp:
  - Stimulus: drive events_rp_i=8'h00 for 3 cycles, then 8'h06.
  - Required: full_o=1 while rp_sync is 0 or two-hot; no acks in that window; fill_o holds its value.
- Async reset mid-burst:
  - Stimulus: assert rst_ni low between clock edges after 3 writes.
  - Required: wt=8'h01, fill_o=0, events_da_o=0 and evt_ack_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/soc_event_token_tx.sv
// Round-robin arbiter that writes tagged events from NB_CH producers into a
// token-ring slot buffer read by the cluster through a one-hot read pointer.
module soc_event_token_tx #(
  parameter int unsigned NB_CH        = 4,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned CH_W         = (NB_CH > 1) ? $clog2(NB_CH) : 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NB_CH-1:0]                         evt_valid_i,
  input  logic [NB_CH*EVNT_WIDTH-1:0]              evt_data_i,
  output logic [NB_CH-1:0]                         evt_ack_o,
  output logic [BUFFER_DEPTH-1:0]                  events_wt_o,
  input  logic [BUFFER_DEPTH-1:0]                  events_rp_i,
  output logic [BUFFER_DEPTH*(CH_W+EVNT_WIDTH)-1:0] events_da_o,
  output logic                                     full_o,
  output logic [$clog2(BUFFER_DEPTH):0]            fill_o
);

  localparam int unsigned IDX_W  = $clog2(BUFFER_DEPTH);
  localparam int unsigned FILL_W = IDX_W + 1;
  localparam int unsigned SLOT_W = CH_W + EVNT_WIDTH;

  logic [BUFFER_DEPTH-1:0]                   wt_q;
  logic [BUFFER_DEPTH-1:0]                   wt_rot;
  logic [BUFFER_DEPTH-1:0]                   wt_next;
  logic [SYNC_STAGES-1:0][BUFFER_DEPTH-1:0]  sync_q;
  logic [BUFFER_DEPTH-1:0]                   rp_sync;
  logic [BUFFER_DEPTH-1:0][SLOT_W-1:0]       slot_q;
  logic [CH_W-1:0]                           rr_q;
  logic [CH_W-1:0]                           rr_next;
  logic [CH_W-1:0]                           winner;
  logic [CH_W-1:0]                           cand;
  logic [EVNT_WIDTH-1:0]                     data_sel;
  logic [FILL_W-1:0]                         fill_q;
  logic [FILL_W-1:0]                         fill_next;
  logic                                      found;
  logic                                      full;
  logic                                      accept;
  logic                                      rp_onehot;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [BUFFER_DEPTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  assign rp_sync = sync_q[SYNC_STAGES-1];
  assign wt_rot  = {wt_q[BUFFER_DEPTH-2:0], wt_q[BUFFER_DEPTH-1]};

  // Zero or multi-hot pointer during a reader transition reads as full.
  assign full      = ((rp_sync & wt_rot) != '0) || (rp_sync == '0);
  assign rp_onehot = (rp_sync != '0) &&
                     ((rp_sync & (rp_sync - BUFFER_DEPTH'(1))) == '0);

  // First requester at or above rr_q, wrapping modulo NB_CH.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NB_CH; i++) begin
      cand = CH_W'((32'(rr_q) + 32'(i)) % NB_CH);
      if (!found && evt_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NB_CH; i++) begin
      if (CH_W'(i) == winner) data_sel = evt_data_i[i*EVNT_WIDTH +: EVNT_WIDTH];
    end
  end

  assign accept    = rst_ni && found && !full;
  assign evt_ack_o = accept ? (NB_CH'(1) << winner) : '0;
  assign wt_next   = accept ? wt_rot : wt_q;
  assign rr_next   = CH_W'((32'(winner) + 32'd1) % NB_CH);
  assign fill_next = FILL_W'((32'(oh2idx(wt_next)) + BUFFER_DEPTH
                              - 32'(oh2idx(rp_sync))) % BUFFER_DEPTH);

  // Read-pointer synchroniser, reset to the reader's reset position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= BUFFER_DEPTH'(1);
    end else begin
      sync_q[0] <= events_rp_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wt_q <= BUFFER_DEPTH'(1);
      rr_q <= '0;
    end else if (accept) begin
      wt_q <= wt_rot;
      rr_q <= rr_next;
    end
  end

  // Slot under the write token captures {ch_id, payload}; reads never clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      for (int s = 0; s < BUFFER_DEPTH; s++) begin
        if (accept && wt_q[s]) slot_q[s] <= {winner, data_sel};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= '0;
    end else if (rp_onehot) begin
      fill_q <= fill_next;
    end
  end

  assign events_wt_o = wt_q;
  assign events_da_o = slot_q;
  assign full_o      = full;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_soc_event_token_tx.sv
// Directed bench for soc_event_token_tx: table of accept/arbitration cycles
// followed by hand-written drain, glitchy-pointer and async-reset sequences.
module tb_soc_event_token_tx;

  localparam int NB_CH = 4;
  localparam int EW    = 8;
  localparam int BD    = 8;
  localparam int CHW   = 2;
  localparam int SW    = CHW + EW;

  logic              clk;
  logic              rst_n;
  logic [NB_CH-1:0]  valid;
  logic [NB_CH*EW-1:0] data;
  logic [NB_CH-1:0]  ack;
  logic [BD-1:0]     wt;
  logic [BD-1:0]     rp;
  logic [BD*SW-1:0]  da;
  logic              full;
  logic [3:0]        fill;

  int tests = 0;
  int fails = 0;

  soc_event_token_tx #(
    .NB_CH(NB_CH), .EVNT_WIDTH(EW), .BUFFER_DEPTH(BD), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(valid), .evt_data_i(data),
    .evt_ack_o(ack), .events_wt_o(wt), .events_rp_i(rp), .events_da_o(da),
    .full_o(full), .fill_o(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ack;
    logic [7:0] wt;
    logic       full;
    logic [3:0] fill;
    int         slot;
    logic [9:0] sval;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] slot_of(input int s);
    return da[s*SW +: SW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0=90 ch1=B1 ch2=A5 ch3=D3 -> slot values 090, 1B1, 2A5, 3D3
    data  = 32'hD3A5B190;
    valid = 4'hF;
    rp    = 8'h01;
    rst_n = 1'b1;

    tbl[0] = '{4'b0100, 4'b0100, 8'h02, 1'b0, 4'd1, 0, 10'h2A5};
    tbl[1] = '{4'b0000, 4'b0000, 8'h02, 1'b0, 4'd1, 0, 10'h2A5};
    tbl[2] = '{4'b1111, 4'b1000, 8'h04, 1'b0, 4'd2, 1, 10'h3D3};
    tbl[3] = '{4'b1111, 4'b0001, 8'h08, 1'b0, 4'd3, 2, 10'h090};
    tbl[4] = '{4'b1111, 4'b0010, 8'h10, 1'b0, 4'd4, 3, 10'h1B1};
    tbl[5] = '{4'b1111, 4'b0100, 8'h20, 1'b0, 4'd5, 4, 10'h2A5};
    tbl[6] = '{4'b0011, 4'b0001, 8'h40, 1'b0, 4'd6, 5, 10'h090};
    tbl[7] = '{4'b0011, 4'b0010, 8'h80, 1'b1, 4'd7, 6, 10'h1B1};
    tbl[8] = '{4'b0001, 4'b0000, 8'h80, 1'b1, 4'd7, 7, 10'h000};

    #1 rst_n = 1'b0;
    #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_wt", 32'(wt), 32'h01);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_fill", 32'(fill), 32'h0);
    chk("reset_da_zero", 32'(da == '0), 32'h1);
    valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      valid = tbl[i].valid;
      #1;
      chk($sformatf("row%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      step();
      chk($sformatf("row%0d_wt", i), 32'(wt), 32'(tbl[i].wt));
      chk($sformatf("row%0d_full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("row%0d_fill", i), 32'(fill), 32'(tbl[i].fill));
      chk($sformatf("row%0d_slot%0d", i, tbl[i].slot), 32'(slot_of(tbl[i].slot)), 32'(tbl[i].sval));
    end

    // Reader advances; stall releases two synchroniser cycles later.
    valid = '0;
    rp    = 8'h02;
    step();
    chk("drain_full_1cyc", 32'(full), 32'h1);
    step();
    chk("drain_full_2cyc", 32'(full), 32'h0);
    chk("drain_fill_2cyc", 32'(fill), 32'd7);
    valid = 4'b0001;
    #1;
    chk("wrap_ack", 32'(ack), 32'b0001);
    step();
    chk("wrap_slot7", 32'(slot_of(7)), 32'h090);
    chk("wrap_wt", 32'(wt), 32'h01);
    chk("wrap_fill", 32'(fill), 32'd7);
    chk("wrap_full", 32'(full), 32'h1);

    // Zero then two-hot pointer keeps the buffer stalled and fill frozen.
    rp = 8'h00;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("glitch%0d_ack", k), 32'(ack), 32'h0);
      step();
      if (k == 3) rp = 8'h06;
      if (k == 5) rp = 8'h04;
      chk($sformatf("glitch%0d_full", k), 32'(full), (k < 7) ? 32'h1 : 32'h0);
      chk($sformatf("glitch%0d_fill", k), 32'(fill), 32'd7);
    end
    valid = '0;

    // Fresh start, three writes, then reset between clock edges.
    rp    = 8'h01;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    valid = 4'b0010;
    step();
    step();
    step();
    chk("burst_wt", 32'(wt), 32'h08);
    chk("burst_fill", 32'(fill), 32'd3);
    chk("burst_slot2", 32'(slot_of(2)), 32'h1B1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_wt", 32'(wt), 32'h01);
    chk("async_fill", 32'(fill), 32'h0);
    chk("async_da_zero", 32'(da == '0), 32'h1);
    chk("async_ack", 32'(ack), 32'h0);
    valid = '0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
